div_result_bcd: RTL and testbench

Downstream stage of the 32-bit signed restoring divider: captures signed quotient and remainder on the divider's one-cycle completion pulse and converts each to sign + 10-digit packed BCD by sequential double-dabble (add-3 / shift). Feeds the display/UART formatting logic, which reads digit nibbles directly. One conversion at a time; operand pulses arriving while busy are dropped and flagged.

---
 rtl/div_result_bcd_if.sv | 25 ++
 rtl/div_result_bcd.sv | 137 +++++++++++++
 tb/tb_div_result_bcd.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div_result_bcd_if.sv
// Bundle between the signed divider and its BCD result stage.
// The master side raises div_done_sig with operands; the slave side reports status and BCD results.
// No backpressure: the slave flags pulses it cannot take via overrun.
interface div_result_bcd_if;
    logic        div_done_sig;
    logic [31:0] quotient;
    logic [31:0] reminder;
    logic        busy;
    logic        done_sig;
    logic        overrun;
    logic        q_sign;
    logic [39:0] q_bcd;
    logic        r_sign;
    logic [39:0] r_bcd;

    modport master (
        output div_done_sig, quotient, reminder,
        input  busy, done_sig, overrun, q_sign, q_bcd, r_sign, r_bcd
    );

    modport slave (
        input  div_done_sig, quotient, reminder,
        output busy, done_sig, overrun, q_sign, q_bcd, r_sign, r_bcd
    );
endinterface

// File: rtl/div_result_bcd.sv
// Converts signed quotient/remainder into sign + 10-digit packed BCD by sequential double-dabble.
// Latency: done_sig 65 cycles after the capture edge; busy until the edge after done_sig.
// No backpressure: a div_done_sig taken outside IDLE is dropped and overrun pulses.
module div_result_bcd (
    input  logic             clk,
    input  logic             rst_n,
    div_result_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_bin;
    logic [31:0] r_r_mag;
    logic [39:0] r_work;
    logic [39:0] r_hold;
    logic        r_q_sign_cap;
    logic        r_r_sign_cap;
    logic        r_done;
    logic        r_overrun;
    logic        r_q_sign;
    logic        r_r_sign;
    logic [39:0] r_q_bcd;
    logic [39:0] r_r_bcd;

    logic [39:0] w_adj;
    logic [39:0] w_shift;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic        w_last;

    // Magnitudes of the incoming operands; 0x8000_0000 maps to 2^31 as unsigned
    always_comb begin
        w_q_mag = bus.quotient[31] ? (~bus.quotient + 32'd1) : bus.quotient;
        w_r_mag = bus.reminder[31] ? (~bus.reminder + 32'd1) : bus.reminder;
        w_last  = (r_cnt == 6'd31);
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < 10; i++) begin
            if (r_work[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
        w_shift = {w_adj[38:0], r_bin[31]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: each conversion phase is 32 shifts, DONE lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.div_done_sig) w_state_nxt = CONV_Q;
            CONV_Q:  if (w_last)           w_state_nxt = CONV_R;
            CONV_R:  if (w_last)           w_state_nxt = DONE;
            DONE:                          w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, shift, hand quotient BCD to holding register, publish results in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bin        <= '0;
            r_r_mag      <= '0;
            r_work       <= '0;
            r_hold       <= '0;
            r_q_sign_cap <= 1'b0;
            r_r_sign_cap <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_q_sign     <= 1'b0;
            r_r_sign     <= 1'b0;
            r_q_bcd      <= '0;
            r_r_bcd      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= bus.div_done_sig && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.div_done_sig) begin
                        r_q_sign_cap <= bus.quotient[31];
                        r_r_sign_cap <= bus.reminder[31];
                        r_bin        <= w_q_mag;
                        r_r_mag      <= w_r_mag;
                        r_cnt        <= '0;
                        r_work       <= '0;
                    end
                end
                CONV_Q: begin
                    if (w_last) begin
                        r_hold <= w_shift;
                        r_work <= '0;
                        r_bin  <= r_r_mag;
                        r_cnt  <= '0;
                    end else begin
                        r_work <= w_shift;
                        r_bin  <= {r_bin[30:0], 1'b0};
                        r_cnt  <= r_cnt + 6'd1;
                    end
                end
                CONV_R: begin
                    r_work <= w_shift;
                    r_bin  <= {r_bin[30:0], 1'b0};
                    r_cnt  <= r_cnt + 6'd1;
                end
                DONE: begin
                    r_q_sign <= r_q_sign_cap;
                    r_q_bcd  <= r_hold;
                    r_r_sign <= r_r_sign_cap;
                    r_r_bcd  <= r_work;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: busy covers the conversion plus the done_sig cycle
    always_comb begin
        bus.busy     = (r_state != IDLE) || r_done;
        bus.done_sig = r_done;
        bus.overrun  = r_overrun;
        bus.q_sign   = r_q_sign;
        bus.q_bcd    = r_q_bcd;
        bus.r_sign   = r_r_sign;
        bus.r_bcd    = r_r_bcd;
    end
endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: directed cases plus random operands against a decimal reference.
// Timing is checked against the fixed 65-cycle latency.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_div_result_bcd;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_result_bcd_if bus ();

    div_result_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {sign, packed BCD of |x|} via plain decimal arithmetic
    function automatic logic [40:0] ref_bcd(input logic [31:0] x);
        longint unsigned mag;
        logic [39:0]     bcd;
        mag = x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        bcd = '0;
        for (int d = 0; d < 10; d++) begin
            bcd[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {x[31], bcd};
    endfunction

    function automatic logic [81:0] outs();
        return {bus.q_sign, bus.q_bcd, bus.r_sign, bus.r_bcd};
    endfunction

    // Call at a negedge; returns at the negedge after done_sig has dropped
    task automatic run_conv(input logic [31:0] q, input logic [31:0] r, input string tag);
        logic [40:0] eq;
        logic [40:0] er;
        logic [81:0] snap;
        int          lat;
        int          ov;
        bit          moved;
        eq = ref_bcd(q);
        er = ref_bcd(r);
        snap = outs();
        moved = 0;
        ov = 0;
        bus.div_done_sig = 1'b1;
        bus.quotient     = q;
        bus.reminder     = r;
        @(negedge clk);
        bus.div_done_sig = 1'b0;
        bus.quotient     = $urandom;
        bus.reminder     = $urandom;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done_sig && lat < 200) begin
            if (outs() !== snap) moved = 1;
            @(negedge clk);
            lat++;
            if (bus.overrun) ov++;
        end
        chk({tag, "_lat"},    64'(lat), 64'd65);
        chk({tag, "_stable"}, 64'(moved), 64'd0);
        chk({tag, "_ovr"},    64'(ov), 64'd0);
        chk({tag, "_qs"},     64'(bus.q_sign), 64'(eq[40]));
        chk({tag, "_qbcd"},   64'(bus.q_bcd), 64'(eq[39:0]));
        chk({tag, "_rs"},     64'(bus.r_sign), 64'(er[40]));
        chk({tag, "_rbcd"},   64'(bus.r_bcd), 64'(er[39:0]));
        @(negedge clk);
        chk({tag, "_end"}, 64'({bus.done_sig, bus.busy}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [40:0] eq;
        logic [40:0] er;
        logic [81:0] snap;
        int          lat;
        int          n_ov;
        int          ov_lat;
        int          n_done;
        int          done_lat;
        bit          moved;
        logic [31:0] q;
        logic [31:0] r;

        rst_n            = 1'b0;
        bus.div_done_sig = 1'b0;
        bus.quotient     = '0;
        bus.reminder     = '0;
        #12;
        chk("reset", 64'({bus.busy, bus.done_sig, bus.overrun}), 64'd0);
        chk("reset_out", 64'(|outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_conv(32'd14, 32'd2, "pos");
        run_conv(32'hFFFF_FFF2, 32'hFFFF_FFFE, "neg");
        run_conv(32'h8000_0000, 32'd0, "min");
        run_conv(32'h7FFF_FFFF, 32'h8000_0001, "max");

        // Overrun: second pulse at capture+10 is dropped, third at capture+66 accepted
        q  = 32'd123456789;
        r  = 32'hFFFF_FF85;
        eq = ref_bcd(q);
        er = ref_bcd(r);
        bus.div_done_sig = 1'b1;
        bus.quotient     = q;
        bus.reminder     = r;
        @(negedge clk);
        bus.div_done_sig = 1'b0;
        lat = 0; n_ov = 0; ov_lat = -1; n_done = 0; done_lat = -1;
        while (lat < 65) begin
            bus.div_done_sig = (lat == 9);
            bus.quotient     = ~q;
            bus.reminder     = ~r;
            @(negedge clk);
            lat++;
            bus.div_done_sig = 1'b0;
            if (bus.overrun) begin n_ov++; ov_lat = lat; end
            if (bus.done_sig) begin n_done++; done_lat = lat; end
        end
        chk("ovr_count", 64'(n_ov), 64'd1);
        chk("ovr_when",  64'(ov_lat), 64'd10);
        chk("ovr_done",  64'({n_done[7:0], done_lat[7:0]}), 64'({8'd1, 8'd65}));
        chk("ovr_q",     64'({bus.q_sign, bus.q_bcd}), 64'(eq));
        chk("ovr_r",     64'({bus.r_sign, bus.r_bcd}), 64'(er));
        run_conv(32'd987654321, 32'd42, "third");

        // Reset mid-conversion
        bus.div_done_sig = 1'b1;
        bus.quotient     = 32'd77;
        bus.reminder     = 32'd3;
        @(negedge clk);
        bus.div_done_sig = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 64'({bus.busy, bus.done_sig, bus.overrun}), 64'd0);
        chk("rst_mid_out", 64'(|outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(32'd5, 32'd0, "after_rst");

        // Inputs change without a pulse: nothing moves
        snap  = outs();
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            bus.quotient = $urandom;
            bus.reminder = $urandom;
            @(negedge clk);
            if (bus.busy || bus.done_sig || outs() !== snap) moved = 1;
        end
        chk("idle_hold", 64'(moved), 64'd0);

        // Random operands, with some boundary-biased picks
        for (int i = 0; i < 14; i++) begin
            q = $urandom;
            r = $urandom;
            case ($urandom_range(0, 3))
                0: q = 32'($urandom_range(0, 20)) - 32'd10;
                1: r = 32'h8000_0000 ^ 32'($urandom_range(0, 1));
                default: ;
            endcase
            run_conv(q, r, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
